// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, bar colours
// and the default 640x480@60 timing.
package vga_pkg;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_SOLID  = 3'd1,
    MODE_BARS   = 3'd2,
    MODE_CHECK  = 3'd3,
    MODE_GRAD   = 3'd4,
    MODE_SCROLL = 3'd5,
    MODE_BLK6   = 3'd6,
    MODE_BLK7   = 3'd7
  } mode_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // {r,g,b} on/off per bar, index 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with
// sync, active-region and coordinate decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int XW       = $clog2(H_ACTIVE),
  parameter int YW       = $clog2(V_ACTIVE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_active,
  output logic          o_hs_on,
  output logic          o_vs_on,
  output logic          o_first,
  output logic          o_frame_wrap,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;

  assign w_h_last = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v == VW'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  assign w_active = (r_h < HW'(H_ACTIVE))
                 && (r_v < VW'(V_ACTIVE));

  assign o_active = w_active;
  assign o_hs_on  = (r_h >= HW'(H_ACTIVE + H_FP))
                 && (r_h <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs_on  = (r_v >= VW'(V_ACTIVE + V_FP))
                 && (r_v <  VW'(V_ACTIVE + V_FP + V_SYNC));

  assign o_first      = (r_h == '0) && (r_v == '0);
  assign o_frame_wrap = w_h_last && w_v_last;

  assign o_x = w_active ? r_h[XW-1:0] : '0;
  assign o_y = w_active ? r_v[YW-1:0] : '0;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster timing plus
// per-frame selected pattern, one registered output stage.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter bit SYNC_POL   = 1'b0,
  parameter int OUT_BITS   = 4,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                          vgaclk,
  input  logic                          rst,
  input  logic [2:0]                    mode,
  input  logic [2:0]                    input_red,
  input  logic [2:0]                    input_green,
  input  logic [1:0]                    input_blue,
  output logic                          hsync,
  output logic                          vsync,
  output logic [OUT_BITS-1:0]           red,
  output logic [OUT_BITS-1:0]           green,
  output logic [OUT_BITS-1:0]           blue,
  output logic                          de,
  output logic [$clog2(H_ACTIVE)-1:0]   x,
  output logic [$clog2(V_ACTIVE)-1:0]   y,
  output logic                          frame_start
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  function automatic logic [OUT_BITS-1:0] exp3(
    input logic [2:0] c
  );
    logic [OUT_BITS-1:0] e;
    for (int j = 0; j < OUT_BITS; j++)
      e[OUT_BITS-1-j] = c[2-(j%3)];
    return e;
  endfunction

  function automatic logic [OUT_BITS-1:0] exp2(
    input logic [1:0] c
  );
    logic [OUT_BITS-1:0] e;
    for (int j = 0; j < OUT_BITS; j++)
      e[OUT_BITS-1-j] = c[1-(j%2)];
    return e;
  endfunction

  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;
  logic          w_first;
  logic          w_frame_wrap;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .XW       (XW),
    .YW       (YW)
  ) u_timing (
    .i_clk        (vgaclk),
    .i_rst        (rst),
    .o_active     (w_active),
    .o_hs_on      (w_hs_on),
    .o_vs_on      (w_vs_on),
    .o_first      (w_first),
    .o_frame_wrap (w_frame_wrap),
    .o_x          (w_x),
    .o_y          (w_y)
  );

  mode_e      r_mode;
  logic [2:0] r_lr;
  logic [2:0] r_lg;
  logic [1:0] r_lb;
  logic [7:0] r_frame_cnt;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_mode      <= MODE_PASS;
      r_lr        <= '0;
      r_lg        <= '0;
      r_lb        <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_first) begin
        r_mode <= mode_e'(mode);
        r_lr   <= input_red;
        r_lg   <= input_green;
        r_lb   <= input_blue;
      end
      if (w_frame_wrap)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Pixel (0,0) already uses the values being latched on it
  mode_e      w_mode;
  logic [2:0] w_sr;
  logic [2:0] w_sg;
  logic [1:0] w_sb;

  assign w_mode = w_first ? mode_e'(mode) : r_mode;
  assign w_sr   = w_first ? input_red     : r_lr;
  assign w_sg   = w_first ? input_green   : r_lg;
  assign w_sb   = w_first ? input_blue    : r_lb;

  logic [31:0] w_xw;
  logic [31:0] w_yw;
  logic [31:0] w_sx;
  logic [2:0]  w_bar_idx;
  logic [2:0]  w_bar;
  logic        w_chk;
  logic        w_scr;

  assign w_xw = 32'(w_x);
  assign w_yw = 32'(w_y);
  assign w_sx = w_xw + 32'(r_frame_cnt);

  assign w_bar_idx = 3'(w_xw * 32'd8 / 32'(H_ACTIVE));
  assign w_bar     = BAR_TABLE[w_bar_idx];

  assign w_chk = |(((w_xw ^ w_yw) >> CHECK_LOG2) & 32'd1);
  assign w_scr = |(((w_sx ^ w_yw) >> CHECK_LOG2) & 32'd1);

  logic [OUT_BITS-1:0] w_r;
  logic [OUT_BITS-1:0] w_g;
  logic [OUT_BITS-1:0] w_b;

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    unique case (w_mode)
      MODE_PASS: begin
        w_r = exp3(input_red);
        w_g = exp3(input_green);
        w_b = exp2(input_blue);
      end
      MODE_SOLID: begin
        w_r = exp3(w_sr);
        w_g = exp3(w_sg);
        w_b = exp2(w_sb);
      end
      MODE_BARS: begin
        w_r = {OUT_BITS{w_bar[2]}};
        w_g = {OUT_BITS{w_bar[1]}};
        w_b = {OUT_BITS{w_bar[0]}};
      end
      MODE_CHECK: begin
        w_r = {OUT_BITS{~w_chk}};
        w_g = {OUT_BITS{~w_chk}};
        w_b = {OUT_BITS{~w_chk}};
      end
      MODE_GRAD: begin
        w_r = OUT_BITS'(w_xw >> 2);
        w_g = OUT_BITS'(w_xw >> 2);
        w_b = OUT_BITS'(w_xw >> 2);
      end
      MODE_SCROLL: begin
        w_r = {OUT_BITS{~w_scr}};
        w_g = {OUT_BITS{~w_scr}};
        w_b = {OUT_BITS{~w_scr}};
      end
      default: begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
      end
    endcase
    if (!w_active) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  logic                r_hs;
  logic                r_vs;
  logic                r_de;
  logic                r_fs;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [OUT_BITS-1:0] r_red;
  logic [OUT_BITS-1:0] r_green;
  logic [OUT_BITS-1:0] r_blue;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_hs    <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vs    <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_active;
      r_fs    <= w_first;
      r_x     <= w_x;
      r_y     <= w_y;
      r_red   <= w_r;
      r_green <= w_g;
      r_blue  <= w_b;
    end
  end

  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;
  assign x           = r_x;
  assign y           = r_y;
  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: three configurations against
// a raster model driven by time since reset release.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [2:0] ir = 3'd0;
  logic [2:0] ig = 3'd0;
  logic [1:0] ib = 2'd0;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_de, a_fs;
  logic [3:0] a_r, a_g, a_b;
  logic [9:0] a_x;
  logic [8:0] a_y;

  logic       t_hs, t_vs, t_de, t_fs;
  logic [3:0] t_r, t_g, t_b;
  logic [2:0] t_x;
  logic [1:0] t_y;

  logic       p_hs, p_vs, p_de, p_fs;
  logic [3:0] p_r, p_g, p_b;
  logic [2:0] p_x;
  logic [1:0] p_y;

  vga_pattern_gen u_a (
    .vgaclk(clk), .rst(rst), .mode(mode),
    .input_red(ir), .input_green(ig), .input_blue(ib),
    .hsync(a_hs), .vsync(a_vs),
    .red(a_r), .green(a_g), .blue(a_b),
    .de(a_de), .x(a_x), .y(a_y), .frame_start(a_fs)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .OUT_BITS(4), .CHECK_LOG2(1)
  ) u_t (
    .vgaclk(clk), .rst(rst), .mode(mode),
    .input_red(ir), .input_green(ig), .input_blue(ib),
    .hsync(t_hs), .vsync(t_vs),
    .red(t_r), .green(t_g), .blue(t_b),
    .de(t_de), .x(t_x), .y(t_y), .frame_start(t_fs)
  );

  vga_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .OUT_BITS(4), .CHECK_LOG2(5)
  ) u_p (
    .vgaclk(clk), .rst(rst), .mode(mode),
    .input_red(ir), .input_green(ig), .input_blue(ib),
    .hsync(p_hs), .vsync(p_vs),
    .red(p_r), .green(p_g), .blue(p_b),
    .de(p_de), .x(p_x), .y(p_y), .frame_start(p_fs)
  );

  // {hs, vs, de, fs, x[16], y[16], r, g, b}
  logic [47:0] obs [3];
  assign obs[0] = {a_hs, a_vs, a_de, a_fs, 16'(a_x), 16'(a_y),
                   a_r, a_g, a_b};
  assign obs[1] = {t_hs, t_vs, t_de, t_fs, 16'(t_x), 16'(t_y),
                   t_r, t_g, t_b};
  assign obs[2] = {p_hs, p_vs, p_de, p_fs, 16'(p_x), 16'(p_y),
                   p_r, p_g, p_b};

  int P_HA [3] = '{640, 8, 8};
  int P_HF [3] = '{16, 2, 2};
  int P_HS [3] = '{96, 2, 2};
  int P_HB [3] = '{48, 2, 2};
  int P_VA [3] = '{480, 4, 4};
  int P_VF [3] = '{10, 1, 1};
  int P_VS [3] = '{2, 1, 1};
  int P_VB [3] = '{33, 1, 1};
  int P_PL [3] = '{0, 0, 1};
  int P_CL [3] = '{5, 1, 5};

  int BR [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
  int BG [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int BB [8] = '{1, 0, 1, 0, 1, 0, 1, 0};

  int mc [3];
  int mm [3];
  int mr [3];
  int mg [3];
  int mb [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic int ftot(int id);
    return (P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id])
         * (P_VA[id] + P_VF[id] + P_VS[id] + P_VB[id]);
  endfunction

  // 3-bit level scaled to 0..15, rounded
  function automatic int e3(int c);
    return (c * 30 + 7) / 14;
  endfunction

  function automatic logic [47:0] model(
    int id, int c, int m, int sr, int sg, int sb,
    int lr, int lg, int lb
  );
    int ht, pos, h, v, f, px, py, sq, r, g, b, k, hs0, vs0;
    bit act, hon, von, hs, vs;
    ht  = P_HA[id] + P_HF[id] + P_HS[id] + P_HB[id];
    pos = c % ftot(id);
    h   = pos % ht;
    v   = pos / ht;
    f   = (c / ftot(id)) % 256;
    act = (h < P_HA[id]) && (v < P_VA[id]);
    hs0 = P_HA[id] + P_HF[id];
    vs0 = P_VA[id] + P_VF[id];
    hon = (h >= hs0) && (h < hs0 + P_HS[id]);
    von = (v >= vs0) && (v < vs0 + P_VS[id]);
    hs  = hon ? P_PL[id][0] : !P_PL[id][0];
    vs  = von ? P_PL[id][0] : !P_PL[id][0];
    px  = act ? h : 0;
    py  = act ? v : 0;
    sq  = 1 << P_CL[id];
    r = 0; g = 0; b = 0;
    if (act) begin
      case (m)
        0: begin r = e3(lr); g = e3(lg); b = lb * 5; end
        1: begin r = e3(sr); g = e3(sg); b = sb * 5; end
        2: begin
          k = px * 8 / P_HA[id];
          r = BR[k] * 15; g = BG[k] * 15; b = BB[k] * 15;
        end
        3: begin
          r = ((px / sq + py / sq) % 2 == 0) ? 15 : 0;
          g = r; b = r;
        end
        4: begin r = (px / 4) % 16; g = r; b = r; end
        5: begin
          r = (((px + f) / sq + py / sq) % 2 == 0) ? 15 : 0;
          g = r; b = r;
        end
        default: begin r = 0; g = 0; b = 0; end
      endcase
    end
    return {hs, vs, act, (pos == 0), 16'(px), 16'(py),
            4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic tick();
    logic [47:0] e;
    @(posedge clk);
    #1;
    cyc++;
    for (int id = 0; id < 3; id++) begin
      if (rst) begin
        mc[id] = 0;
        e = {~P_PL[id][0], ~P_PL[id][0], 46'd0};
      end else begin
        if (mc[id] % ftot(id) == 0) begin
          mm[id] = int'(mode);
          mr[id] = int'(ir);
          mg[id] = int'(ig);
          mb[id] = int'(ib);
        end
        e = model(id, mc[id], mm[id], mr[id], mg[id], mb[id],
                  int'(ir), int'(ig), int'(ib));
        mc[id]++;
      end
      checks++;
      assert (obs[id] === e) else begin
        errors++;
        $error("FAIL pix_dut%0d cyc %0d observed %h expected %h",
               id, cyc, obs[id], e);
      end
    end
  endtask

  task automatic run(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        ir = 3'($urandom);
        ig = 3'($urandom);
        ib = 2'($urandom);
      end
      tick();
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    run(n, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wait_fs(int id, int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs[id][44] && n < lim);
  endtask

  initial begin
    int n, hl, hh;
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mm[i] = 0; mr[i] = 0; mg[i] = 0; mb[i] = 0;
    end

    // reset values, then bars on line 0 of the 640 config
    mode = 3'd2;
    do_reset(3);
    tick();
    checks++;
    assert (obs[1][44] === 1'b1) else begin
      errors++;
      $error("FAIL fs_after_release observed %b expected 1",
             obs[1][44]);
    end
    hl = 0; hh = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (obs[1][47] === 1'b0) hl++;
      if (obs[2][47] === 1'b1) hh++;
    end
    checks++;
    assert (hl == 2) else begin
      errors++;
      $error("FAIL hsync_low_cnt observed %0d expected 2", hl);
    end
    checks++;
    assert (hh == 2) else begin
      errors++;
      $error("FAIL hsync_high_cnt observed %0d expected 2", hh);
    end
    wait_fs(1, 200, n);
    wait_fs(1, 200, n);
    checks++;
    assert (n == 98) else begin
      errors++;
      $error("FAIL frame_period observed %0d expected 98", n);
    end
    run(900, 1'b0);

    // solid colour held across mid-frame input and mode changes
    mode = 3'd1; ir = 3'b101; ig = 3'b010; ib = 2'b11;
    do_reset(2);
    tick();
    ir = 3'b010; ig = 3'b111; ib = 2'b00; mode = 3'd3;
    run(50, 1'b0);
    checks++;
    assert (obs[0][11:0] === 12'hB4F) else begin
      errors++;
      $error("FAIL solid_hold observed %h expected b4f",
             obs[0][11:0]);
    end
    run(250, 1'b0);

    // checker on the 640 config
    mode = 3'd3;
    do_reset(1);
    while (mc[0] < 33) tick();
    checks++;
    assert (obs[0][11:0] === 12'h000) else begin
      errors++;
      $error("FAIL check_32_0 observed %h expected 000",
             obs[0][11:0]);
    end
    while (mc[0] < 32 * 800 + 33) tick();
    checks++;
    assert (obs[0][11:0] === 12'hFFF) else begin
      errors++;
      $error("FAIL check_32_32 observed %h expected fff",
             obs[0][11:0]);
    end

    // scroll reaching frame count 32
    mode = 3'd5;
    do_reset(1);
    while (mc[2] < 32 * 98 + 1) tick();
    checks++;
    assert (obs[2][44] === 1'b1 && obs[2][11:0] === 12'h000)
    else begin
      errors++;
      $error("FAIL scroll_f32 observed fs %b rgb %h expected 1 000",
             obs[2][44], obs[2][11:0]);
    end

    // gradient across line 0
    mode = 3'd4;
    do_reset(1);
    run(900, 1'b0);

    // mid-frame reset, then random modes and inputs
    run(137, 1'b0);
    do_reset(1);
    wait_fs(1, 200, n);
    wait_fs(1, 200, n);
    checks++;
    assert (n == 98) else begin
      errors++;
      $error("FAIL period_after_rst observed %0d expected 98", n);
    end
    for (int s = 0; s < 25; s++) begin
      mode = 3'($urandom_range(0, 7));
      run($urandom_range(30, 400), 1'b1);
      if ($urandom_range(0, 3) == 0)
        do_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
